// File: rtl/ddram_resp.sv
// ddram_resp: burst memory responder for a DDRAM-style master port.
// Optional macro DDRAM_RESP_STALL_EN adds pseudo-random LFSR busy stalls.
module ddram_resp #(
   parameter int AW     = 12,
   parameter int RD_LAT = 4
) (
   input  logic        DDRAM_CLK,
   input  logic        RESET_N,
   output logic        DDRAM_BUSY,
   input  logic [7:0]  DDRAM_BURSTCNT,
   input  logic [28:0] DDRAM_ADDR,
   input  logic        DDRAM_RD,
   input  logic        DDRAM_WE,
   input  logic [63:0] DDRAM_DIN,
   input  logic [7:0]  DDRAM_BE,
   output logic [63:0] DDRAM_DOUT,
   output logic        DDRAM_DOUT_READY,
   output logic        proto_err
);
   typedef enum logic [1:0] {IDLE, WBURST, RWAIT, RBURST} state_t;
   state_t        state;
   logic [63:0]   mem [2**AW];
   logic [7:0]    cnt;
   logic [3:0]    lat;
   logic [AW-1:0] idx;
   logic [AW-1:0] a_idx;
   logic [AW-1:0] w_idx;
   logic [7:0]    n;
   logic          wr_en;
   logic          stall;
   logic          unused_addr;
   assign a_idx       = DDRAM_ADDR[AW-1:0];
   assign unused_addr = ^DDRAM_ADDR[28:AW];
   assign n           = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
`ifdef DDRAM_RESP_STALL_EN
   logic [7:0] lfsr;
   always_ff @(posedge DDRAM_CLK)
      lfsr <= !RESET_N ? 8'hA5 : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign stall = (lfsr[1:0] == 2'b11) && (state == IDLE || state == WBURST);
`else
   assign stall = 1'b0;
`endif
   assign DDRAM_BUSY = state == RWAIT || state == RBURST || stall;
   assign wr_en      = DDRAM_WE && !DDRAM_BUSY && (state == IDLE || state == WBURST);
   assign w_idx      = (state == IDLE) ? a_idx : idx;

   // store is deliberately outside the reset domain so contents survive reset
   always_ff @(posedge DDRAM_CLK)
      if (RESET_N && wr_en)
         for (int b = 0; b < 8; b++)
            if (DDRAM_BE[b]) mem[w_idx][8*b +: 8] <= DDRAM_DIN[8*b +: 8];

   always_ff @(posedge DDRAM_CLK) begin
      if (!RESET_N) begin
         state            <= IDLE;
         cnt              <= 8'd0;
         lat              <= 4'd0;
         idx              <= '0;
         DDRAM_DOUT       <= 64'd0;
         DDRAM_DOUT_READY <= 1'b0;
         proto_err        <= 1'b0;
      end else begin
         DDRAM_DOUT_READY <= 1'b0;
         case (state)
            IDLE:
               if (wr_en) begin
                  if (DDRAM_RD || DDRAM_BURSTCNT == 8'd0) proto_err <= 1'b1;
                  idx <= a_idx + AW'(1);
                  cnt <= n - 8'd1;
                  if (n != 8'd1) state <= WBURST;
               end else if (DDRAM_RD && !DDRAM_BUSY) begin
                  if (DDRAM_BURSTCNT == 8'd0) proto_err <= 1'b1;
                  idx   <= a_idx;
                  cnt   <= n;
                  lat   <= 4'(RD_LAT - 2);
                  state <= RWAIT;
               end
            WBURST: begin
               if (DDRAM_RD && !DDRAM_BUSY) proto_err <= 1'b1;
               if (wr_en) begin
                  idx <= idx + AW'(1);
                  cnt <= cnt - 8'd1;
                  if (cnt == 8'd1) state <= IDLE;
               end
            end
            // beat 0 is registered on the last RWAIT edge so it appears RD_LAT cycles after acceptance
            RWAIT:
               if (lat == 4'd0) begin
                  DDRAM_DOUT       <= mem[idx];
                  DDRAM_DOUT_READY <= 1'b1;
                  idx              <= idx + AW'(1);
                  cnt              <= cnt - 8'd1;
                  state            <= RBURST;
               end else lat <= lat - 4'd1;
            RBURST:
               if (cnt == 8'd0) state <= IDLE;
               else begin
                  DDRAM_DOUT       <= mem[idx];
                  DDRAM_DOUT_READY <= 1'b1;
                  idx              <= idx + AW'(1);
                  cnt              <= cnt - 8'd1;
               end
         endcase
      end
   end
endmodule

// File: tb/tb_ddram_resp.sv
// tb_ddram_resp: vector table, directed corner sequences and random traffic for ddram_resp.
// Works with or without DDRAM_RESP_STALL_EN defined.
module tb_ddram_resp;
   localparam int RD_LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        busy;
   logic [7:0]  bcnt = 8'd1;
   logic [28:0] addr = '0;
   logic        rd = 1'b0;
   logic        we = 1'b0;
   logic [63:0] din = '0;
   logic [7:0]  be = '0;
   logic [63:0] dout;
   logic        dout_ready;
   logic        perr;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] model [4096];
   logic [63:0] wdata [256];
   logic [63:0] rdata [256];

   typedef struct {
      logic [28:0] wa;
      logic [63:0] d;
      logic [7:0]  be;
      logic [28:0] ra;
      logic [63:0] exp;
   } vec_t;
   vec_t vt [6];

   ddram_resp #(.AW(12), .RD_LAT(RD_LAT)) dut (
      .DDRAM_CLK(clk), .RESET_N(rst_n), .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(bcnt),
      .DDRAM_ADDR(addr), .DDRAM_RD(rd), .DDRAM_WE(we), .DDRAM_DIN(din), .DDRAM_BE(be),
      .DDRAM_DOUT(dout), .DDRAM_DOUT_READY(dout_ready), .proto_err(perr)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [11:0] ix(input logic [28:0] a, input int i);
      return 12'(int'(a[11:0]) + i);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // called right after driving a request at a negedge; returns in the acceptance cycle
   task automatic wait_ready(output logic ok);
      int guard = 0;
      while (busy && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      ok = !busy;
      if (!ok) chk("busy_timeout", 64'(busy), 64'd0);
   endtask

   task automatic write_burst(input logic [28:0] a, input logic [7:0] bc, input logic [7:0] bmask,
                              input int gap_at, input int gap_len, input logic rd_too);
      int n = (bc == 8'd0) ? 1 : int'(bc);
      logic ok;
      for (int i = 0; i < n; i++) begin
         if (i == gap_at)
            repeat (gap_len) begin
               @(negedge clk);
               we = 1'b0;
               rd = 1'b0;
            end
         @(negedge clk);
         we = 1'b1; din = wdata[i]; be = bmask; addr = a; bcnt = bc; rd = rd_too && i == 0;
         wait_ready(ok);
         if (!ok) break;
         for (int b = 0; b < 8; b++)
            if (bmask[b]) model[ix(a, i)][8*b +: 8] = wdata[i][8*b +: 8];
      end
      @(negedge clk);
      we = 1'b0;
      rd = 1'b0;
   endtask

   task automatic read_burst(input logic [28:0] a, input logic [7:0] n);
      logic ok;
      @(negedge clk);
      rd = 1'b1; addr = a; bcnt = n;
      wait_ready(ok);
      if (ok)
         for (int k = 1; k <= RD_LAT + int'(n); k++) begin
            @(negedge clk);
            rd = 1'b0;
            chk("rd_ready", 64'(dout_ready), 64'(k >= RD_LAT && k < RD_LAT + int'(n)));
            if (k < RD_LAT + int'(n)) chk("rd_busy", 64'(busy), 64'd1);
            if (k >= RD_LAT && k < RD_LAT + int'(n)) begin
               rdata[k - RD_LAT] = dout;
               chk("rd_data", dout, model[ix(a, k - RD_LAT)]);
            end
            if (k == RD_LAT + int'(n)) begin
               chk("rd_hold", dout, model[ix(a, int'(n) - 1)]);
`ifndef DDRAM_RESP_STALL_EN
               chk("rd_busy_end", 64'(busy), 64'd0);
`endif
            end
         end
      rd = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; rd = 1'b0; we = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic ok;
      logic [31:0] r;
      int lo;
      vt[0] = '{29'h10,   64'h0,                  8'hFF, 29'h10,   64'h0};
      vt[1] = '{29'h10,   64'h1122334455667788,   8'h0F, 29'h10,   64'h0000000055667788};
      vt[2] = '{29'h10,   64'hAABBCCDDEEFF0011,   8'hF0, 29'h10,   64'hAABBCCDD55667788};
      vt[3] = '{29'h10,   64'hFFFFFFFFFFFFFFFF,   8'h81, 29'h10,   64'hFFBBCCDD556677FF};
      vt[4] = '{29'h11,   64'h0123456789ABCDEF,   8'hFF, 29'h1011, 64'h0123456789ABCDEF};
      vt[5] = '{29'h11,   64'h0,                  8'h00, 29'h11,   64'h0123456789ABCDEF};

      do_reset();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(dout_ready), 64'd0);
      chk("rst_dout", dout, 64'd0);
      chk("rst_perr", 64'(perr), 64'd0);

      for (int i = 0; i < 6; i++) begin
         wdata[0] = vt[i].d;
         write_burst(vt[i].wa, 8'd1, vt[i].be, -1, 0, 1'b0);
         read_burst(vt[i].ra, 8'd1);
         chk("table", rdata[0], vt[i].exp);
      end

      for (int i = 0; i < 4; i++) wdata[i] = 64'(i + 1);
      write_burst(29'h20, 8'd4, 8'hFF, 1, 2, 1'b0);
      read_burst(29'h20, 8'd4);
      for (int i = 0; i < 4; i++) chk("burst4", rdata[i], 64'(i + 1));

      wdata[0] = 64'hAAAA; wdata[1] = 64'hBBBB;
      write_burst(29'hFFF, 8'd2, 8'hFF, -1, 0, 1'b0);
      read_burst(29'h000, 8'd1);
      chk("wrap_lo", rdata[0], 64'hBBBB);
      read_burst(29'h1FFF, 8'd1);
      chk("wrap_hi", rdata[0], 64'hAAAA);
      chk("perr_clean", 64'(perr), 64'd0);

      wdata[0] = 64'h4040; wdata[1] = 64'h4141;
      write_burst(29'h40, 8'd2, 8'hFF, -1, 0, 1'b0);
      wdata[0] = 64'h5050;
      write_burst(29'h40, 8'd0, 8'hFF, -1, 0, 1'b0);
      chk("bc0_perr", 64'(perr), 64'd1);
      read_burst(29'h40, 8'd2);
      chk("bc0_data", rdata[0], 64'h5050);
      chk("bc0_next", rdata[1], 64'h4141);
      do_reset();
      chk("perr_cleared", 64'(perr), 64'd0);

      wdata[0] = 64'hC0FFEE;
      write_burst(29'h30, 8'd1, 8'hFF, -1, 0, 1'b1);
      for (int k = 0; k < RD_LAT + 2; k++) begin
         @(negedge clk);
         chk("both_ready", 64'(dout_ready), 64'd0);
      end
      chk("both_perr", 64'(perr), 64'd1);
      read_burst(29'h30, 8'd1);
      chk("both_data", rdata[0], 64'hC0FFEE);
      chk("both_perr_sticky", 64'(perr), 64'd1);
      do_reset();

      for (int i = 0; i < 4; i++) wdata[i] = 64'(i + 5);
      write_burst(29'h24, 8'd4, 8'hFF, -1, 0, 1'b0);
      @(negedge clk);
      rd = 1'b1; addr = 29'h20; bcnt = 8'd8;
      wait_ready(ok);
      if (ok) begin
         for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            rd = 1'b0;
            if (k >= RD_LAT) chk("abort_beat", dout, model[ix(29'h20, k - RD_LAT)]);
         end
         rst_n = 1'b0;
         @(negedge clk);
         chk("abort_ready", 64'(dout_ready), 64'd0);
         chk("abort_busy", 64'(busy), 64'd0);
         chk("abort_dout", dout, 64'd0);
         rst_n = 1'b1;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_quiet", 64'(dout_ready), 64'd0);
         end
      end
      rd = 1'b0;
      read_burst(29'h20, 8'd8);
      for (int i = 0; i < 8; i++) chk("abort_keep", rdata[i], 64'(i + 1));

      for (int i = 0; i < 64; i++) wdata[i] = {$urandom, $urandom};
      write_burst(29'h0, 8'd64, 8'hFF, -1, 0, 1'b0);
      for (int t = 0; t < 1000; t++) begin
         r = $urandom;
         lo = $urandom_range(0, 60);
         wdata[0] = {$urandom, $urandom};
         write_burst({r[28:12], 6'b0, 6'(lo)}, 8'd1, 8'($urandom), -1, 0, 1'b0);
         r = $urandom;
         read_burst({r[28:12], 6'b0, 6'(lo)}, 8'(1 + (t % 3)));
      end
      chk("rand_perr", 64'(perr), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
